// File: rtl/sd_cmd_receiver.sv
// sd_cmd_receiver
//   Receive side of the SD host CMD line. Once armed, waits for the card's
//   start bit, then deserializes a 48-bit (R1/R3/R6/R7) or 136-bit (R2)
//   response. It checks the transmission bit, the R2 reserved bits, the end
//   bit and CRC7, and reports completion with a one-cycle pulse.
//
// Ports:
//   ex_clk              system clock, all logic on its rising edge
//   reset_n             asynchronous active-low reset
//   sd_clk_en           one-cycle strobe marking an SD clock rising edge
//   receive_en          arm pulse, accepted only in IDLE
//   R2_response         latched at arm: 1 = 136-bit frame, 0 = 48-bit frame
//   crc_ignore          latched at arm: 1 = do not flag CRC mismatches
//   sd_cmd_in           synchronized CMD pin
//   response[126:0]     received payload, MSB first
//   sd_receive_finished one-cycle pulse at end of frame or timeout
//   crc_response_err    CRC7 mismatch
//   frame_err           bad transmission bit, R2 reserved bits or end bit
//   timeout_err         no start bit within NCR_MAX strobes
//   busy                high whenever not IDLE
module sd_cmd_receiver #(
    parameter int unsigned NCR_MAX = 64
) (
    input  logic         ex_clk,
    input  logic         reset_n,
    input  logic         sd_clk_en,
    input  logic         receive_en,
    input  logic         R2_response,
    input  logic         crc_ignore,
    input  logic         sd_cmd_in,
    output logic [126:0] response,
    output logic         sd_receive_finished,
    output logic         crc_response_err,
    output logic         frame_err,
    output logic         timeout_err,
    output logic         busy
);

    localparam int unsigned TO_W = $clog2(NCR_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            r2_q;
    logic            crc_ign_q;
    logic [126:0]    sreg;
    logic [6:0]      crc;
    logic [7:0]      bit_cnt;
    logic [TO_W-1:0] to_cnt;

    // Frame geometry, counted in bits after the start bit.
    logic [7:0]      last_bit;
    logic [7:0]      crc_first;
    logic [7:0]      crc_last;

    logic            start_seen;
    logic            to_hit;
    logic            end_bit;

    assign last_bit  = r2_q ? 8'd134 : 8'd46;
    assign crc_first = r2_q ? 8'd7   : 8'd0;
    assign crc_last  = r2_q ? 8'd126 : 8'd38;

    assign start_seen = (state == WAIT_START) && sd_clk_en && !sd_cmd_in;
    assign to_hit     = (state == WAIT_START) && sd_clk_en && sd_cmd_in &&
                        (to_cnt == TO_W'(NCR_MAX - 1));
    assign end_bit    = (state == SHIFT) && sd_clk_en && (bit_cnt == last_bit);

    assign busy                = (state != IDLE);
    assign sd_receive_finished = (state == DONE);

    // CRC7, generator x^7 + x^3 + 1, MSB-first serial update.
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (receive_en) state_nxt = WAIT_START;
            end
            WAIT_START: begin
                if (start_seen || to_hit) state_nxt = (start_seen) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (end_bit) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ex_clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_q             <= 1'b0;
            crc_ign_q        <= 1'b0;
            sreg             <= '0;
            crc              <= '0;
            bit_cnt          <= '0;
            to_cnt           <= '0;
            response         <= '0;
            crc_response_err <= 1'b0;
            frame_err        <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (receive_en) begin
                        r2_q             <= R2_response;
                        crc_ign_q        <= crc_ignore;
                        crc              <= '0;
                        to_cnt           <= '0;
                        crc_response_err <= 1'b0;
                        frame_err        <= 1'b0;
                        timeout_err      <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (sd_clk_en) begin
                        if (!sd_cmd_in) begin
                            bit_cnt <= '0;
                            // Only the 48-bit CRC covers the start bit.
                            if (!r2_q) crc <= crc7_step(crc, 1'b0);
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                            if (to_hit) timeout_err <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (sd_clk_en) begin
                        bit_cnt <= bit_cnt + 8'd1;
                        sreg    <= {sreg[125:0], sd_cmd_in};
                        if (bit_cnt >= crc_first && bit_cnt <= crc_last)
                            crc <= crc7_step(crc, sd_cmd_in);
                        if (bit_cnt == 8'd0 && sd_cmd_in)
                            frame_err <= 1'b1;
                        if (r2_q && bit_cnt >= 8'd1 && bit_cnt <= 8'd6 && !sd_cmd_in)
                            frame_err <= 1'b1;
                        if (end_bit) begin
                            // The end bit is not yet in sreg: the seven bits
                            // just before it (the received CRC) sit in sreg[6:0].
                            if (!sd_cmd_in) frame_err <= 1'b1;
                            if (!crc_ign_q && (crc != sreg[6:0]))
                                crc_response_err <= 1'b1;
                            if (r2_q) response <= sreg;
                            else      response <= {sreg[45:0], sd_cmd_in, 80'b0};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_receiver.sv
module tb_sd_cmd_receiver;

    localparam int unsigned NCR = 64;

    logic         ex_clk;
    logic         reset_n;
    logic         sd_clk_en;
    logic         receive_en;
    logic         R2_response;
    logic         crc_ignore;
    logic         sd_cmd_in;
    logic [126:0] response;
    logic         sd_receive_finished;
    logic         crc_response_err;
    logic         frame_err;
    logic         timeout_err;
    logic         busy;

    sd_cmd_receiver #(.NCR_MAX(NCR)) dut (
        .ex_clk              (ex_clk),
        .reset_n             (reset_n),
        .sd_clk_en           (sd_clk_en),
        .receive_en          (receive_en),
        .R2_response         (R2_response),
        .crc_ignore          (crc_ignore),
        .sd_cmd_in           (sd_cmd_in),
        .response            (response),
        .sd_receive_finished (sd_receive_finished),
        .crc_response_err    (crc_response_err),
        .frame_err           (frame_err),
        .timeout_err         (timeout_err),
        .busy                (busy)
    );

    initial ex_clk = 1'b0;
    always #5 ex_clk = ~ex_clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic [126:0] last_resp = '0;

    typedef struct {
        logic [126:0] resp;
        logic         crc_e;
        logic         frm_e;
        logic         to_e;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic         r2;
        logic         ci;
        logic [5:0]   hdr;       // index (48-bit) or reserved bits (R2)
        logic [31:0]  arg;
        logic [126:0] cid;       // CID/CSD[127:1]; [6:0] replaced by the CRC
        logic [1:0]   crc_mode;  // 0 good, 1 bit0 flipped, 2 all ones
        logic         tbit;
        logic         endb;
        int           idle;
        int           div;
        int           rearm_at;  // bit index for a mid-frame receive_en, -1 none
        logic         done_arm;  // pulse receive_en during the DONE cycle
        logic         exp_crc;
        logic         exp_frm;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [126:0] act, input logic [126:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Remainder of M(x)*x^7 divided by x^7+x^3+1; msg[n-1] is the first bit.
    function automatic logic [6:0] crc7_div(input logic [127:0] msg, input int n);
        logic [134:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i+7] = msg[i];
        for (int i = n + 6; i >= 7; i--)
            if (w[i]) w[i -: 8] = w[i -: 8] ^ 8'h89;
        return w[6:0];
    endfunction

    always @(negedge ex_clk) begin
        if (reset_n && sd_receive_finished) begin
            exp_t e;
            pulses++;
            if (sb.size() == 0) begin
                check("unexpected_finish", 127'd1, 127'd0);
            end else begin
                e = sb.pop_front();
                check("response", response, e.resp);
                check("crc_response_err", {126'b0, crc_response_err}, {126'b0, e.crc_e});
                check("frame_err", {126'b0, frame_err}, {126'b0, e.frm_e});
                check("timeout_err", {126'b0, timeout_err}, {126'b0, e.to_e});
            end
        end
    end

    task automatic strobe(input logic b, input int div);
        for (int k = 1; k < div; k++) begin
            sd_clk_en = 1'b0;
            sd_cmd_in = 1'($urandom_range(0, 1));
            @(posedge ex_clk); #1;
        end
        sd_clk_en = 1'b1;
        sd_cmd_in = b;
        @(posedge ex_clk); #1;
        sd_clk_en = 1'b0;
        sd_cmd_in = 1'b1;
    endtask

    task automatic arm(input logic r2, input logic ci);
        R2_response = r2;
        crc_ignore  = ci;
        receive_en  = 1'b1;
        @(posedge ex_clk); #1;
        receive_en  = 1'b0;
        // Opposite values afterwards: the receiver must use what it latched.
        R2_response = ~r2;
        crc_ignore  = ~ci;
        check("busy_after_arm", {126'b0, busy}, 127'd1);
    endtask

    task automatic wait_sb_empty();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge ex_clk); #1;
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL finish_wait: %0d responses outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic [6:0]   good;
        logic [6:0]   sent;
        logic [126:0] cid;
        logic [134:0] fb;
        int           nb;
        exp_t         e;

        fb = '0;
        if (!v.r2) begin
            good = crc7_div({88'b0, 1'b0, v.tbit, v.hdr, v.arg}, 40);
            sent = (v.crc_mode == 2'd0) ? good :
                   (v.crc_mode == 2'd1) ? (good ^ 7'h01) : 7'h7F;
            fb[46:0] = {v.tbit, v.hdr, v.arg, sent, v.endb};
            nb = 47;
            e.resp = {v.tbit, v.hdr, v.arg, sent, v.endb, 80'b0};
        end else begin
            cid  = v.cid;
            good = crc7_div({8'b0, cid[126:7]}, 120);
            cid[6:0] = (v.crc_mode == 2'd0) ? good :
                       (v.crc_mode == 2'd1) ? (good ^ 7'h01) : 7'h7F;
            fb = {v.tbit, v.hdr, cid, v.endb};
            nb = 135;
            e.resp = cid;
        end
        e.crc_e = v.exp_crc;
        e.frm_e = v.exp_frm;
        e.to_e  = 1'b0;

        arm(v.r2, v.ci);
        sb.push_back(e);
        exp_pulses++;
        last_resp = e.resp;

        for (int i = 0; i < v.idle; i++) strobe(1'b1, v.div);
        strobe(1'b0, v.div);
        for (int i = 0; i < nb; i++) begin
            if (i == v.rearm_at) receive_en = 1'b1;
            strobe(fb[nb-1-i], v.div);
            receive_en = 1'b0;
            if (i == nb - 2)
                check({tag, "_early_finish"}, {126'b0, sd_receive_finished}, 127'd0);
        end
        check({tag, "_fin_latency"}, {126'b0, sd_receive_finished}, 127'd1);
        if (v.done_arm) receive_en = 1'b1;
        @(posedge ex_clk); #1;
        receive_en = 1'b0;
        wait_sb_empty();
        check({tag, "_busy_after"}, {126'b0, busy}, 127'd0);
        check({tag, "_pulse_count"}, 127'(pulses), 127'(exp_pulses));
    endtask

    initial begin
        vec_t r1;
        reset_n = 1'b0; sd_clk_en = 1'b0; receive_en = 1'b0;
        R2_response = 1'b0; crc_ignore = 1'b0; sd_cmd_in = 1'b1;

        //            r2    ci    hdr     arg            cid                                          mode  tb    eb   idle div rearm done  crc   frm
        vecs[0] = '{1'b0, 1'b0, 6'd55, 32'h00000120, '0,                                          2'd0, 1'b0, 1'b1, 6, 2, -1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 6'd55, 32'h00000120, '0,                                          2'd1, 1'b0, 1'b1, 6, 2, -1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 6'h3F, 32'h80FF8000, '0,                                          2'd2, 1'b0, 1'b1, 3, 3, -1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 6'h3F, 32'h0,        {63'h3456_789A_BCDE_F012, 64'h0FED_CBA9_8765_4321}, 2'd0, 1'b0, 1'b1, 2, 1, -1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 6'h3E, 32'h0,        {63'h3456_789A_BCDE_F012, 64'h0FED_CBA9_8765_4321}, 2'd0, 1'b0, 1'b1, 2, 2, -1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 6'd17, 32'hDEADBEEF, '0,                                          2'd0, 1'b0, 1'b0, 1, 3, -1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 6'd8,  32'h000001AA, '0,                                          2'd0, 1'b1, 1'b1, 0, 2, -1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 6'd55, 32'h00000120, '0,                                          2'd0, 1'b0, 1'b1, 0, 1, 10, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge ex_clk);
        #1;
        check("rst_response", response, '0);
        check("rst_finished", {126'b0, sd_receive_finished}, 127'd0);
        check("rst_errs", {124'b0, crc_response_err, frame_err, timeout_err}, 127'd0);
        check("rst_busy", {126'b0, busy}, 127'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge ex_clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Timeout: CMD held high for NCR_MAX strobes.
        begin
            exp_t e;
            arm(1'b0, 1'b0);
            e.resp = last_resp; e.crc_e = 1'b0; e.frm_e = 1'b0; e.to_e = 1'b1;
            sb.push_back(e);
            exp_pulses++;
            for (int i = 0; i < int'(NCR) - 1; i++) strobe(1'b1, 2);
            check("timeout_early", {125'b0, sd_receive_finished, busy}, 127'd1);
            strobe(1'b1, 2);
            check("timeout_latency", {126'b0, sd_receive_finished}, 127'd1);
            @(posedge ex_clk); #1;
            wait_sb_empty();
            check("timeout_busy_after", {126'b0, busy}, 127'd0);
            check("timeout_pulse_count", 127'(pulses), 127'(exp_pulses));
        end

        // Abort: reset asserted at bit 20 of a frame.
        arm(1'b0, 1'b0);
        strobe(1'b1, 2);
        strobe(1'b0, 2);
        for (int i = 0; i < 20; i++) strobe(1'($urandom_range(0, 1)), 2);
        reset_n = 1'b0;
        #2;
        check("abort_response", response, '0);
        check("abort_flags", {123'b0, sd_receive_finished, crc_response_err, frame_err, timeout_err}, 127'd0);
        check("abort_busy", {126'b0, busy}, 127'd0);
        @(posedge ex_clk); #1;
        reset_n = 1'b1;
        last_resp = '0;
        for (int i = 0; i < 30; i++) strobe(1'($urandom_range(0, 1)), 1);
        check("abort_no_finish", 127'(pulses), 127'(exp_pulses));
        check("abort_idle", {126'b0, busy}, 127'd0);

        r1 = vecs[0];
        run_vec(r1, "rearm");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
